// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Issues word-aligned fetches under a
// credit limit, queues returned instructions with their addresses, and presents
// the oldest one to decode. Responses to fetches that were already in flight
// when a redirect arrived are dropped by counting them down.
//
// Optional feature: define FETCH_DELAY_SLOT_EN to keep one delay-slot
// instruction (the next sequential one) across every redirect.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam ptr_t          PTR_ONE = ptr_t'(1);
    localparam cnt_t          CNT_ONE = cnt_t'(1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    entry_t      mem [DEPTH];
    ptr_t        rd_ptr, rd_ptr_n;
    ptr_t        wr_ptr, wr_ptr_n;
    cnt_t        count, count_n;
    cnt_t        outstanding, outstanding_n;
    cnt_t        discard, discard_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] resp_pc, resp_pc_n;
    logic        pop, resp, issue, push;
    entry_t      push_entry;
    logic [CW:0] credit_used;

`ifdef FETCH_DELAY_SLOT_EN
    // keep_flag: the next live response is the delay slot and is pushed at keep_pc.
    // tail: number of pre-redirect fetches behind the delay slot, dropped after it.
    // slot_fetch: no delay-slot fetch is in flight yet, so issue one at keep_pc.
    logic        keep_flag, keep_flag_n;
    logic [31:0] keep_pc, keep_pc_n;
    cnt_t        tail, tail_n;
    logic        slot_fetch, slot_fetch_n;
    cnt_t        live;
`endif

    // Every fetch in flight already owns a queue slot, so the queue can never overflow.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = reset & ~redirect & (credit_used < DEPTH_C);

`ifdef FETCH_DELAY_SLOT_EN
    assign imem_addr = slot_fetch ? keep_pc : fetch_pc;
`else
    assign imem_addr = fetch_pc;
`endif

    assign dec_instr = mem[rd_ptr].instr;
    assign dec_pc    = mem[rd_ptr].pc;

    // Next-state: pop first, then the response, then the issue, and a redirect overrides last.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        pop           = dec_valid & dec_ready;
        resp          = imem_rvalid & (outstanding != '0);
        issue         = imem_req & imem_gnt;
        rd_ptr_n      = rd_ptr;
        wr_ptr_n      = wr_ptr;
        count_n       = count;
        outstanding_n = outstanding;
        discard_n     = discard;
        fetch_pc_n    = fetch_pc;
        resp_pc_n     = resp_pc;
        push          = 1'b0;
        push_entry    = '{pc: resp_pc, instr: imem_rdata};
`ifdef FETCH_DELAY_SLOT_EN
        keep_flag_n   = keep_flag;
        keep_pc_n     = keep_pc;
        tail_n        = tail;
        slot_fetch_n  = slot_fetch;
        live          = '0;
`endif

        // NOTE: blocking assignments here let each step build on the previous one's result.
        if (pop) begin
            rd_ptr_n = rd_ptr + PTR_ONE;
            count_n  = count_n - CNT_ONE;
        end

        if (resp) begin
            outstanding_n = outstanding_n - CNT_ONE;
            if (discard != '0) begin
                discard_n = discard - CNT_ONE;
            end
`ifdef FETCH_DELAY_SLOT_EN
            else if (keep_flag) begin
                push          = 1'b1;
                push_entry.pc = keep_pc;
                keep_flag_n   = 1'b0;
                discard_n     = tail;
            end
`endif
            else begin
                push      = 1'b1;
                resp_pc_n = resp_pc + 32'd4;
            end
        end

        if (push) begin
            wr_ptr_n = wr_ptr + PTR_ONE;
            count_n  = count_n + CNT_ONE;
        end

        if (issue) begin
            outstanding_n = outstanding_n + CNT_ONE;
`ifdef FETCH_DELAY_SLOT_EN
            if (slot_fetch) begin
                slot_fetch_n = 1'b0;
            end else begin
                fetch_pc_n = fetch_pc + 32'd4;
            end
`else
            fetch_pc_n = fetch_pc + 32'd4;
`endif
        end

        if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (count_n != '0) begin
                // Keep only the head entry as the delay slot; everything in flight is stale.
                wr_ptr_n     = rd_ptr_n + PTR_ONE;
                count_n      = CNT_ONE;
                discard_n    = outstanding_n;
                keep_flag_n  = 1'b0;
                slot_fetch_n = 1'b0;
                tail_n       = '0;
            end else begin
                // Queue empty: the oldest live fetch (or a new one) becomes the delay slot.
                live        = outstanding_n - discard_n;
                keep_flag_n = 1'b1;
                keep_pc_n   = keep_flag ? keep_pc : resp_pc_n;
                if (live == '0) begin
                    slot_fetch_n = 1'b1;
                    tail_n       = '0;
                end else begin
                    tail_n = live - CNT_ONE;
                end
            end
`else
            wr_ptr_n  = rd_ptr_n;
            count_n   = '0;
            discard_n = outstanding_n;
`endif
            fetch_pc_n = redirect_pc;
            resp_pc_n  = redirect_pc;
        end
    end

    // Control state register; dec_valid is registered from the next queue occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            dec_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together on the edge.
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            count       <= count_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            fetch_pc    <= fetch_pc_n;
            resp_pc     <= resp_pc_n;
            dec_valid   <= (count_n != '0);
        end
    end

`ifdef FETCH_DELAY_SLOT_EN
    // Delay-slot bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            keep_flag  <= 1'b0;
            keep_pc    <= '0;
            tail       <= '0;
            slot_fetch <= 1'b0;
        end else begin
            keep_flag  <= keep_flag_n;
            keep_pc    <= keep_pc_n;
            tail       <= tail_n;
            slot_fetch <= slot_fetch_n;
        end
    end
`endif

    // Queue storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; the pointers and count alone decide what is valid.
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus a randomized run of fetch_queue.
// The reference model tracks only the program-order stream decode must see:
// sequential addresses, replaced by the target on a redirect (after one
// delay-slot instruction when FETCH_DELAY_SLOT_EN is defined), with the
// instruction word derived from its address by the memory model.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready   = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_issued = 0;

    // Memory model: in-order pending fetches with the cycle they were granted.
    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    int          resp_pct = 100;
    logic        mem_hold = 1'b0;
    logic        stray    = 1'b0;

    // Stream model.
    logic [31:0] exp_pc       = RESET_PC;
    logic        slot_pending = 1'b0;
    logic [31:0] slot_pc      = '0;
    logic [31:0] slot_target  = '0;
    logic [31:0] pops[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, sample at #1 after the negedge, update models.
    task automatic step();
        logic [31:0] want;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else if (!mem_hold && pend_addr.size() > 0) begin
            if (pend_cyc[0] < cyc && $urandom_range(99) < resp_pct) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(pend_addr[0]);
            end
        end
        #1;
        if (redirect) check("req_in_redirect", {31'b0, imem_req}, 32'd0);
        if (imem_req) begin
            check("req_align", {30'b0, imem_addr[1:0]}, 32'd0);
            check("req_credit", {31'b0, pend_addr.size() < DEPTH}, 32'd1);
        end
        if (dec_valid && dec_ready) begin
            want = slot_pending ? slot_pc : exp_pc;
            check("dec_pc", dec_pc, want);
            check("dec_instr", dec_instr, word_of(want));
            pops.push_back(dec_pc);
            if (slot_pending) begin
                exp_pc       = slot_target;
                slot_pending = 1'b0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (redirect) begin
`ifdef FETCH_DELAY_SLOT_EN
            if (!slot_pending) begin
                slot_pc      = exp_pc;
                slot_pending = 1'b1;
            end
            slot_target = redirect_pc;
`else
            exp_pc = redirect_pc;
`endif
        end
        if (imem_req && imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_cyc.push_back(cyc);
            n_issued++;
        end
        if (imem_rvalid && !stray && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
        end
        @(posedge clock);
        @(negedge clock);
        redirect = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        stray       = 1'b0;
        mem_hold    = 1'b0;
        resp_pct    = 100;
        @(posedge clock);
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset        = 1'b1;
        pend_addr.delete();
        pend_cyc.delete();
        exp_pc       = RESET_PC;
        slot_pending = 1'b0;
        pops.delete();
        n_issued     = 0;
    endtask

    // Run with decode ready until n instructions are delivered or the budget runs out.
    task automatic collect(input int n, input int budget);
        int k;
        pops.delete();
        k = 0;
        while (pops.size() < n && k < budget) begin
            step();
            k++;
        end
        check("collect_timeout", {31'b0, pops.size() >= n}, 32'd1);
    endtask

    logic [31:0] expv[4];
    logic [31:0] tgt;

    initial begin
        // Back-to-back streaming with a one-cycle memory.
        do_reset();
        imem_gnt = 1'b1; dec_ready = 1'b1;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            pops.delete();
            step();
            check("stream_pop", {31'b0, pops.size() == 1}, 32'd1);
            if (pops.size() == 1) check("stream_pc", pops[0], RESET_PC + 32'(4 * i));
        end

        // Decode stalled: the credit limit caps issued fetches at DEPTH.
        do_reset();
        imem_gnt = 1'b1; dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("stall_issued", n_issued, DEPTH);
        check("stall_req_low", {31'b0, imem_req}, 32'd0);
        check("stall_dec_valid", {31'b0, dec_valid}, 32'd1);
        dec_ready = 1'b1;
        collect(4, 20);
        for (int i = 0; i < 4 && i < pops.size(); i++) check("stall_drain_pc", pops[i], 32'(4 * i));

        // Redirect with two fetches in flight and an empty queue.
        do_reset();
        imem_gnt = 1'b1; dec_ready = 1'b0; mem_hold = 1'b1;
        step(); step();
        check("rd2_outstanding", pend_addr.size(), 32'd2);
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        mem_hold = 1'b0; dec_ready = 1'b1;
        collect(2, 30);
`ifdef FETCH_DELAY_SLOT_EN
        expv[0] = 32'h0;   expv[1] = 32'h100;
`else
        expv[0] = 32'h100; expv[1] = 32'h104;
`endif
        for (int i = 0; i < 2 && i < pops.size(); i++) check("rd2_pc", pops[i], expv[i]);

        // Redirect while the queue holds pc 8 and 12.
        do_reset();
        imem_gnt = 1'b1; dec_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        imem_gnt = 1'b0; dec_ready = 1'b1;
        step(); step();
        dec_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        imem_gnt = 1'b1; dec_ready = 1'b1;
        collect(2, 30);
`ifdef FETCH_DELAY_SLOT_EN
        expv[0] = 32'h8;   expv[1] = 32'h200;
`else
        expv[0] = 32'h200; expv[1] = 32'h204;
`endif
        for (int i = 0; i < 2 && i < pops.size(); i++) check("rdq_pc", pops[i], expv[i]);

        // Reset with three fetches in flight, then stray responses after release.
        do_reset();
        imem_gnt = 1'b1; dec_ready = 1'b0; mem_hold = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("mid_outstanding", pend_addr.size(), 32'd3);
        do_reset();
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        imem_gnt = 1'b0; stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stray_ignored", {31'b0, dec_valid}, 32'd0);
        end
        stray = 1'b0; imem_gnt = 1'b1; dec_ready = 1'b1;
        collect(3, 30);
        for (int i = 0; i < 3 && i < pops.size(); i++) check("post_rst_pc", pops[i], RESET_PC + 32'(4 * i));

        // Address wrap after a redirect near the top of the address space.
        do_reset();
        imem_gnt = 1'b1; dec_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
`ifdef FETCH_DELAY_SLOT_EN
        collect(4, 40);
        expv[0] = RESET_PC; expv[1] = 32'hFFFF_FFF8; expv[2] = 32'hFFFF_FFFC; expv[3] = 32'h0;
        for (int i = 0; i < 4 && i < pops.size(); i++) check("wrap_pc", pops[i], expv[i]);
`else
        collect(3, 40);
        expv[0] = 32'hFFFF_FFF8; expv[1] = 32'hFFFF_FFFC; expv[2] = 32'h0;
        for (int i = 0; i < 3 && i < pops.size(); i++) check("wrap_pc", pops[i], expv[i]);
`endif

        // Randomized traffic: grant, response delay, decode stalls and redirects.
        do_reset();
        resp_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            imem_gnt  = ($urandom_range(99) < 70);
            dec_ready = ($urandom_range(99) < 60);
            if ($urandom_range(99) < 4) begin
                tgt = $urandom;
                tgt[1:0] = 2'b00;
                if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(3) * 4);
                redirect    = 1'b1;
                redirect_pc = tgt;
            end
            step();
        end
        imem_gnt = 1'b1; dec_ready = 1'b1; resp_pct = 100;
        collect(8, 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
